// File: rtl/seg_scan_ctrl_if.sv
// Application-side bundle of the seven-segment scan controller: display data in, board pins and frame strobe out.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blink_en;
  logic                load;
  logic                hex_mode;
  logic                blank_lz;
  logic [DIGITS-1:0]   sel;
  logic [7:0]          seg;
  logic                frame_done;

  modport master (
    output data_in, dp_in, blink_en, load, hex_mode, blank_lz,
    input  sel, seg, frame_done
  );

  modport slave (
    input  data_in, dp_in, blink_en, load, hex_mode, blank_lz,
    output sel, seg, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with dead time, blink, leading-zero
// blanking and frame-synchronous (tear-free) update of the displayed data.
module seg_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 500,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
  localparam int CNT_W = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0]  LAST_DIG = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'(BLINK_DIV - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_e;

  // Active-high g..a pattern; non-decimal nibbles collapse to a dash outside hex mode.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    if (!hex && nib > 4'd9) pat = 7'h40;
    return pat;
  endfunction

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [BLK_W-1:0]    blink_cnt;
  blink_phase_e        blink_phase;

  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blink, act_blink;
  logic                pend_valid;

  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;

  logic slot_end, frame_end;
  assign slot_end  = (slot_cnt == LAST_CNT);
  assign frame_end = slot_end && (dig_idx == LAST_DIG);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rstn) begin
      slot_cnt    <= '0;
      dig_idx     <= '0;
      blink_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
      if (blink_cnt == LAST_BLK) begin
        blink_cnt   <= '0;
        blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A load on the boundary cycle lands in pending while the old pending goes live.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
    end else begin
      if (frame_end && pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blink <= pend_blink;
      end
      if (bus.load) begin
        pend_data  <= bus.data_in;
        pend_dp    <= bus.dp_in;
        pend_blink <= bus.blink_en;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

  logic [3:0] cur_nib;
  logic       higher_zero, lz_blank, blink_blank, dead;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_nib     = act_data[4*int'(dig_idx) +: 4];
    higher_zero = ((act_data >> (4*int'(dig_idx))) == '0);
    lz_blank    = bus.blank_lz && (dig_idx != '0) && higher_zero;
    blink_blank = (blink_phase == BLINK_OFF) && act_blink[dig_idx];
    dead        = int'(slot_cnt) < DEAD;
    sel_d       = SEL_OFF;
    seg_d       = SEG_OFF;
    if (!dead) begin
      sel_d = (DIGITS'(1) << dig_idx) ^ SEL_OFF;
      if (!lz_blank && !blink_blank)
        seg_d = {act_dp[dig_idx], decode(cur_nib, bus.hex_mode)} ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      sel_q <= SEL_OFF;
      seg_q <= SEG_OFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_end && !rstn;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios then random loads,
// compared every cycle against a time-arithmetic reference model.
module tb_seg_scan_ctrl;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 6;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 40;
  localparam int FRAME     = SCAN_DIV * DIGITS;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .BLINK_DIV(BLINK_DIV),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: t counts clk edges since the last reset edge.
  int         t = 0;
  logic [15:0] m_pend_data, m_act_data;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_blink, m_act_blink;
  bit          m_pend_valid;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic void expect_out(output logic [3:0] es, output logic [7:0] eg);
    int  slot = t % SCAN_DIV;
    int  d    = (t / SCAN_DIV) % DIGITS;
    bit  on   = ((t / BLINK_DIV) % 2) == 0;
    bit  allz = 1'b1;
    logic [3:0] nib = m_act_data[4*d +: 4];
    logic [7:0] lit;
    for (int j = d; j < DIGITS; j++)
      if (m_act_data[4*j +: 4] != 4'h0) allz = 1'b0;
    es = 4'hF;
    eg = 8'hFF;
    if (slot >= DEAD) begin
      es = ~(4'b0001 << d);
      if ((bus.blank_lz && d != 0 && allz) || (!on && m_act_blink[d])) lit = 8'h00;
      else if (!bus.hex_mode && nib > 4'd9) lit = {m_act_dp[d], 7'h40};
      else lit = {m_act_dp[d], seg_tbl[nib]};
      eg = ~lit;
    end
  endfunction

  task automatic tick();
    logic [3:0] es;
    logic [7:0] eg;
    bit fe;
    if (rstn) begin
      es = 4'hF;
      eg = 8'hFF;
      t = 0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_blink = '0; m_pend_valid = 1'b0;
      m_act_data  = '0; m_act_dp  = '0; m_act_blink  = '0;
    end else begin
      expect_out(es, eg);
      fe = (t % FRAME) == FRAME - 1;
      if (fe && m_pend_valid) begin
        m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blink = m_pend_blink;
      end
      if (bus.load) begin
        m_pend_data = bus.data_in; m_pend_dp = bus.dp_in; m_pend_blink = bus.blink_en;
        m_pend_valid = 1'b1;
      end else if (fe) begin
        m_pend_valid = 1'b0;
      end
      t++;
    end
    @(posedge clk);
    #1;
    check("sel", bus.sel, es);
    check("seg", bus.seg, eg);
    check("frame_done", bus.frame_done, (!rstn && (t % FRAME) == FRAME - 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blink_en = bl;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic run_until(input int phase);
    int n = 0;
    while ((t % FRAME) != phase && n < FRAME) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b1;
    run(n);
    rstn = 1'b0;
  endtask

  initial begin
    rstn         = 1'b1;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blink_en = '0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b1;
    bus.blank_lz = 1'b0;

    // Reset, then a little over one frame to reach the first frame_done.
    do_reset(3);
    run(FRAME + 6);

    // Mid-frame load: current frame keeps old data, next frame shows 1 2 A F.
    run_until(8);
    do_load(16'h12AF, 4'b0000, 4'b0000);
    run(2 * FRAME);

    // Dash rendering for A and F outside hex mode.
    bus.hex_mode = 1'b0;
    run(FRAME);
    bus.hex_mode = 1'b1;

    // Leading-zero blanking with a decimal point on a blanked zero digit.
    bus.blank_lz = 1'b1;
    do_load(16'h0005, 4'b0100, 4'b0000);
    run(2 * FRAME);
    bus.blank_lz = 1'b0;
    run(FRAME);

    // Blink on digit 0 across several blink half-periods.
    bus.blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000, 4'b0001);
    run(4 * BLINK_DIV);

    // Earlier load in a frame, then another on the boundary cycle itself.
    run_until(10);
    do_load(16'h3456, 4'b0010, 4'b0000);
    run_until(FRAME - 1);
    do_load(16'hBEEF, 4'b1001, 4'b0000);
    run(2 * FRAME);

    // Reset in slot 2 aborts the frame without frame_done.
    run_until(2 * SCAN_DIV + 3);
    do_reset(1);
    run(FRAME + 2);

    // Random loads, modes and occasional resets.
    for (int it = 0; it < 40; it++) begin
      bus.hex_mode = 1'($urandom_range(0, 1));
      bus.blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0)
        do_load(16'($urandom_range(0, 255)), 4'($urandom), 4'($urandom));
      run($urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
